// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared definitions for the 8-bit adder datapath and its checking-side
//   result decoder: operand width, FSM state encoding and counter width.
package adder_pkg;

  localparam int ADD_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit counter must reach ADD_WIDTH (the sum carries one extra bit).
  localparam int ADD_CNT_W = $clog2(ADD_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/adder_result_decoder_fsub.sv
// full_subtractor_bit
//   Single-bit subtractor cell: d = x - y - bin, with borrow out.
// Ports:
//   x    in  minuend bit
//   y    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/adder_result_decoder.sv
// adder_result_decoder
//   Recovers operand a from a captured adder sum and the known operand b
//   (a = sum - b), one bit per clock LSB first through a single subtractor
//   cell. Flags sums no WIDTH-bit a could have produced.
// Ports:
//   clk    in  system clock, rising edge
//   rst    in  synchronous active-high reset
//   start  in  request pulse, sampled only while idle
//   sum    in  [WIDTH:0]   adder result, captured on accepted start
//   b      in  [WIDTH-1:0] known operand, captured on accepted start
//   busy   out high while an operation is running or completing
//   done   out one-cycle pulse when a/err are updated
//   a      out [WIDTH-1:0] recovered operand, held until next done
//   err    out set when sum < b or sum - b does not fit in WIDTH bits
import adder_pkg::*;

module adder_result_decoder #(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum_r;
  logic [WIDTH:0]   b_r;
  logic             borrow;
  logic [WIDTH-1:0] diff_r;

  logic d_bit;
  logic borrow_next;
  logic last;

  // Operands are shifted right each RUN cycle, so bit k is always at [0].
  full_subtractor_bit u_fsub (
    .x    (sum_r[0]),
    .y    (b_r[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (borrow_next)
  );

  assign last = (cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sum_r  <= '0;
      b_r    <= '0;
      borrow <= 1'b0;
      diff_r <= '0;
      a      <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum_r  <= sum;
            b_r    <= {1'b0, b};
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          sum_r  <= sum_r >> 1;
          b_r    <= b_r >> 1;
          borrow <= borrow_next;
          diff_r <= {d_bit, diff_r[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          // On the final bit, diff_r already holds the low WIDTH difference
          // bits; d_bit is difference bit WIDTH and borrow_next the borrow out.
          if (last) begin
            a   <= diff_r;
            err <= borrow_next | d_bit;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_decoder.sv
module tb_adder_result_decoder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] sum;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] a;
  logic       err;

  int n_tests;
  int n_fail;

  adder_result_decoder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sum   (sum),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .a     (a),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from idle and check latency, result and pulse width.
  task automatic do_op(input string tag, input logic [8:0] s, input logic [7:0] bb,
                       input logic [7:0] exp_a, input logic exp_err);
    int lat;
    sum   = s;
    b     = bb;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 99;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, lat, 9);
    check({tag, "_a"}, a, exp_a);
    check({tag, "_err"}, err, exp_err);
    tick();
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    int nlow;
    int dc [3];

    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    start = 1'b0;
    sum   = '0;
    b     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_a", a, 0);
    check("rst_err", err, 0);

    do_op("first", 9'd11, 8'd10, 8'd1, 1'b0);
    do_op("c102", 9'd102, 8'd99, 8'd3, 1'b0);
    do_op("c167", 9'd167, 8'd66, 8'd101, 1'b0);
    do_op("max", 9'd510, 8'd255, 8'd255, 1'b0);
    do_op("zero", 9'd0, 8'd0, 8'd0, 1'b0);
    do_op("under", 9'd5, 8'd10, 8'd251, 1'b1);
    do_op("over", 9'd300, 8'd0, 8'd44, 1'b1);
    do_op("errclr", 9'd20, 8'd7, 8'd13, 1'b0);

    // Second start during RUN plus input changes must be ignored.
    sum = 9'd200; b = 8'd50; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    sum = 9'd1; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    sum = 9'd77; b = 8'd3;
    ndone = 0;
    lat = 99;
    for (int n = 4; n <= 30; n++) begin
      tick();
      if (done) begin
        ndone++;
        if (lat == 99) begin
          lat = n;
          check("ign_a", a, 150);
          check("ign_err", err, 0);
        end
      end
    end
    check("ign_lat", lat, 9);
    check("ign_ndone", ndone, 1);

    // Reset on the 4th RUN edge discards the operation.
    sum = 9'd200; b = 8'd50; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_a", a, 0);
    check("mrst_err", err, 0);
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (done) ndone++;
    end
    check("mrst_nodone", ndone, 0);
    do_op("after_rst", 9'd9, 8'd4, 8'd5, 1'b0);

    // Back-to-back with start held high.
    sum = 9'd66; b = 8'd33; start = 1'b1;
    tick();
    ndone = 0;
    nlow  = 0;
    dc    = '{-1, -1, -1};
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (done) begin
        if (ndone < 3) dc[ndone] = c;
        ndone++;
        check("b2b_a", a, 33);
        check("b2b_err", err, 0);
      end
      if (!busy) nlow++;
    end
    start = 1'b0;
    check("b2b_ndone", ndone, 3);
    check("b2b_first", dc[0], 9);
    check("b2b_second", dc[1], 20);
    check("b2b_third", dc[2], 31);
    check("b2b_idle_cycles", nlow, 3);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
